// File: rtl/axi4_burst_memory_peripheral.sv
// Burst-capable AXI4 responder backed by a register-array memory.
// One address handshake per burst; write and read channels run independently.
module axi4_burst_memory_peripheral #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int LEN_WIDTH     = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] awaddr,
  input  logic [LEN_WIDTH-1:0]     awlen,
  input  logic [2:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic                     bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDRESS_WIDTH-1:0] araddr,
  input  logic [LEN_WIDTH-1:0]     arlen,
  input  logic [2:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [31:0]              error_count
);
  localparam int DEPTH = 2**ADDRESS_WIDTH;
  localparam logic [2:0] BURST_FIXED = 3'b001;
  localparam logic [2:0] BURST_INCR  = 3'b010;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_TWO = LEN_WIDTH'(2);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic {R_IDLE, R_DATA} rState_t;

  function automatic logic [ADDRESS_WIDTH-1:0] stepAddr(input logic [ADDRESS_WIDTH-1:0] a,
                                                        input logic fixed);
    return fixed ? a : a + ADDR_ONE;
  endfunction

  function automatic logic [LEN_WIDTH-1:0] lenOf(input logic [LEN_WIDTH-1:0] x);
    return (x == '0) ? LEN_ONE : x;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  wState_t                  wState_q;
  logic [ADDRESS_WIDTH-1:0] wAddr_q;
  logic [LEN_WIDTH-1:0]     wCount_q;
  logic                     wFixed_q;
  logic                     wFlag_q;
  logic                     awready_q, wready_q, bvalid_q, bresp_q;

  rState_t                  rState_q;
  logic [ADDRESS_WIDTH-1:0] rAddr_q;
  logic [LEN_WIDTH-1:0]     rCount_q;
  logic                     rFixed_q;
  logic                     arready_q, rvalid_q, rlast_q;
  logic [DATA_WIDTH-1:0]    rdata_q;

  logic [31:0] errCount_q, errCount_d;
  logic [1:0]  wErrInc, rErrInc;
  logic [32:0] errSum;

  logic awBeat, wBeat, bBeat, arBeat, rBeat;
  logic awLenZero, awBadBurst, arLenZero, arBadBurst, arFixed, wMismatch;

  assign awBeat     = (wState_q == W_IDLE) && awvalid && awready_q;
  assign wBeat      = (wState_q == W_DATA) && wvalid && wready_q;
  assign bBeat      = (wState_q == W_RESP) && bvalid_q && bready;
  assign arBeat     = (rState_q == R_IDLE) && arvalid && arready_q;
  assign rBeat      = (rState_q == R_DATA) && rvalid_q && rready;
  assign awLenZero  = (awlen == '0);
  assign arLenZero  = (arlen == '0);
  assign awBadBurst = (awburst != BURST_FIXED) && (awburst != BURST_INCR);
  assign arBadBurst = (arburst != BURST_FIXED) && (arburst != BURST_INCR);
  assign arFixed    = (arburst == BURST_FIXED);
  assign wMismatch  = wlast != (wCount_q == LEN_ONE);

  // Both channels may report errors in the same cycle, so increments are summed.
  always_comb begin
    wErrInc = 2'd0;
    rErrInc = 2'd0;
    if (awBeat) wErrInc = 2'(awLenZero) + 2'(awBadBurst);
    else if (wBeat && wMismatch) wErrInc = 2'd1;
    if (arBeat) rErrInc = 2'(arLenZero) + 2'(arBadBurst);
    errSum     = {1'b0, errCount_q} + 33'(wErrInc) + 33'(rErrInc);
    errCount_d = errSum[32] ? 32'hFFFF_FFFF : errSum[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) errCount_q <= '0;
    else       errCount_q <= errCount_d;
  end

  // Memory is deliberately left out of reset; an aborted burst keeps its committed beats.
  always_ff @(posedge clock) begin
    if (!reset && wBeat) mem_q[wAddr_q] <= wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wState_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 1'b0;
      wAddr_q   <= '0;
      wCount_q  <= '0;
      wFixed_q  <= 1'b0;
      wFlag_q   <= 1'b0;
    end else begin
      case (wState_q)
        W_IDLE: if (awBeat) begin
          wAddr_q   <= awaddr;
          wCount_q  <= lenOf(awlen);
          wFixed_q  <= (awburst == BURST_FIXED);
          wFlag_q   <= awLenZero | awBadBurst;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          wState_q  <= W_DATA;
        end
        W_DATA: if (wBeat) begin
          wAddr_q  <= stepAddr(wAddr_q, wFixed_q);
          wCount_q <= wCount_q - LEN_ONE;
          if (wMismatch) wFlag_q <= 1'b1;
          if (wCount_q == LEN_ONE) begin
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= !(wFlag_q | wMismatch);
            wState_q <= W_RESP;
          end
        end
        W_RESP: if (bBeat) begin
          bvalid_q  <= 1'b0;
          wFlag_q   <= 1'b0;
          awready_q <= 1'b1;
          wState_q  <= W_IDLE;
        end
        default: wState_q <= W_IDLE;
      endcase
    end
  end

  // The next beat is prefetched on each handshake so beats stream without bubbles.
  always_ff @(posedge clock) begin
    if (reset) begin
      rState_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rAddr_q   <= '0;
      rCount_q  <= '0;
      rFixed_q  <= 1'b0;
    end else begin
      case (rState_q)
        R_IDLE: if (arBeat) begin
          arready_q <= 1'b0;
          rdata_q   <= mem_q[araddr];
          rvalid_q  <= 1'b1;
          rlast_q   <= (lenOf(arlen) == LEN_ONE);
          rAddr_q   <= stepAddr(araddr, arFixed);
          rCount_q  <= lenOf(arlen);
          rFixed_q  <= arFixed;
          rState_q  <= R_DATA;
        end
        R_DATA: if (rBeat) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            rState_q  <= R_IDLE;
          end else begin
            rdata_q  <= mem_q[rAddr_q];
            rAddr_q  <= stepAddr(rAddr_q, rFixed_q);
            rCount_q <= rCount_q - LEN_ONE;
            rlast_q  <= (rCount_q == LEN_TWO);
          end
        end
        default: rState_q <= R_IDLE;
      endcase
    end
  end

  assign awready     = awready_q;
  assign wready      = wready_q;
  assign bvalid      = bvalid_q;
  assign bresp       = bresp_q;
  assign arready     = arready_q;
  assign rvalid      = rvalid_q;
  assign rlast       = rlast_q;
  assign rdata       = rdata_q;
  assign error_count = errCount_q;
endmodule

// File: tb/tb_axi4_burst_memory_peripheral.sv
// Scoreboard bench: stimulus tasks push expected R beats / B responses from a
// behavioural memory model; a negedge monitor pops and compares them.
module tb_axi4_burst_memory_peripheral;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int LW = 5;
  localparam logic [2:0] FIXED = 3'b001;
  localparam logic [2:0] INCR  = 3'b010;
  localparam logic [2:0] WRAP  = 3'b100;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [LW-1:0] awlen = '0, arlen = '0;
  logic [2:0]    awburst = INCR, arburst = INCR;
  logic          awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
  logic          bready = 1'b0, rready = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic          awready, wready, bresp, bvalid, arready, rlast, rvalid;
  logic [DW-1:0] rdata;
  logic [31:0]   error_count;

  always #5 clock = ~clock;

  axi4_burst_memory_peripheral #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clock(clock), .reset(reset),
    .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .error_count(error_count)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } rExp_t;

  int          total = 0;
  int          bad = 0;
  int          errModel = 0;
  int          rMode = 0;
  logic [31:0] modelMem [16];
  rExp_t       rQ [$];
  logic        bQ [$];
  logic [31:0] wdQ [$];
  logic        rPat [$];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: timed out waiting, expected a handshake", name);
  endtask

  function automatic bit legalBurst(input logic [2:0] b);
    return (b == FIXED) || (b == INCR);
  endfunction

  // rready: always high, random, or a per-cycle pattern consumed while rvalid is up.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rMode == 2 && rPat.size() > 0) begin
        if (rvalid) rready = rPat.pop_front();
      end else if (rMode == 1) rready = 1'($urandom_range(0, 1));
      else rready = 1'b1;
    end
  end

  initial begin
    rExp_t       e;
    logic        eb;
    logic        prevValid = 1'b0, prevReady = 1'b0, prevLast = 1'b0;
    logic [31:0] prevData = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (rvalid) begin
          if (prevValid && !prevReady) begin
            checkOutput("rHoldData", rdata, prevData);
            checkOutput("rHoldLast", rlast, prevLast);
          end
          if (rready) begin
            if (rQ.size() == 0) begin
              total++; bad++;
              $display("[TB] FAIL rUnexpected: got beat data %0h, expected no beat", rdata);
            end else begin
              e = rQ.pop_front();
              checkOutput("rdata", rdata, e.data);
              checkOutput("rlast", rlast, e.last);
            end
          end
        end
        if (bvalid && bready) begin
          if (bQ.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL bUnexpected: got bresp %0b, expected no response", bresp);
          end else begin
            eb = bQ.pop_front();
            checkOutput("bresp", bresp, eb);
          end
        end
      end
      prevValid = rvalid; prevReady = rready; prevData = rdata; prevLast = rlast;
    end
  end

  // wlast is driven on every beat from index wlastFrom onward; abortAfter>=0 resets mid-burst.
  task automatic doWrite(input logic [3:0] addr, input int xlen, input logic [2:0] burst,
                         input int wlastFrom, input int abortAfter);
    int len, n;
    logic [3:0] a;
    logic flag, wl;
    logic [31:0] d;
    len  = (xlen == 0) ? 1 : xlen;
    a    = addr;
    flag = (xlen == 0) || !legalBurst(burst);
    if (xlen == 0) errModel++;
    if (!legalBurst(burst)) errModel++;
    @(posedge clock); #1;
    awaddr = addr; awlen = LW'(xlen); awburst = burst; awvalid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!awready && n < 50);
    if (!awready) begin timeoutFail("awHandshake"); awvalid = 1'b0; return; end
    @(posedge clock); #1;
    awvalid = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == abortAfter) begin
        wvalid = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        errModel = 0;
        checkOutput("awreadyAfterReset", awready, 1);
        checkOutput("wreadyAfterReset", wready, 0);
        checkOutput("bvalidAfterReset", bvalid, 0);
        checkOutput("errAfterReset", error_count, 0);
        return;
      end
      repeat ($urandom_range(0, 2)) begin wvalid = 1'b0; @(posedge clock); #1; end
      d  = (wdQ.size() > 0) ? wdQ.pop_front() : $urandom;
      wl = (i >= wlastFrom);
      wdata = d; wlast = wl; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clock); n++; end while (!wready && n < 50);
      if (!wready) begin timeoutFail("wHandshake"); wvalid = 1'b0; return; end
      modelMem[a] = d;
      if (wl != (i == len - 1)) begin flag = 1'b1; errModel++; end
      if (burst != FIXED) a = a + 4'd1;
      @(posedge clock); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    bQ.push_back(!flag);
    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    bready = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!bvalid && n < 50);
    if (!bvalid) begin timeoutFail("bHandshake"); bready = 1'b0; bQ.delete(); return; end
    @(posedge clock); #1;
    bready = 1'b0;
    checkOutput("awreadyAfterB", awready, 1);
    checkOutput("errCountW", error_count, errModel);
  endtask

  task automatic doRead(input logic [3:0] addr, input int xlen, input logic [2:0] burst);
    int len, n;
    logic [3:0] a;
    len = (xlen == 0) ? 1 : xlen;
    a   = addr;
    if (xlen == 0) errModel++;
    if (!legalBurst(burst)) errModel++;
    for (int i = 0; i < len; i++) begin
      rQ.push_back('{data: modelMem[a], last: (i == len - 1)});
      if (burst != FIXED) a = a + 4'd1;
    end
    @(posedge clock); #1;
    araddr = addr; arlen = LW'(xlen); arburst = burst; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (!arready && n < 50);
    if (!arready) begin timeoutFail("arHandshake"); arvalid = 1'b0; rQ.delete(); return; end
    @(posedge clock); #1;
    arvalid = 1'b0;
    @(negedge clock);
    checkOutput("rFirstValid", rvalid, 1);
    #1;
    n = 0;
    while (rQ.size() != 0 && n < 300) begin @(negedge clock); #1; n++; end
    if (rQ.size() != 0) begin timeoutFail("rBeats"); rQ.delete(); return; end
    @(negedge clock); #1;
    checkOutput("arreadyAfterLast", arready, 1);
    checkOutput("rvalidAfterLast", rvalid, 0);
    checkOutput("errCountR", error_count, errModel);
  endtask

  task automatic applyStimulus();
    logic [3:0] a;
    logic [2:0] b;
    int xl, len, wlf, sel;
    for (int k = 0; k < 40; k++) begin
      a   = 4'($urandom_range(0, 15));
      xl  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      sel = $urandom_range(0, 5);
      b   = (sel < 3) ? INCR : (sel == 3) ? FIXED : (sel == 4) ? WRAP : 3'b111;
      len = (xl == 0) ? 1 : xl;
      if ($urandom_range(0, 1) == 1) begin
        wlf = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : len - 1;
        doWrite(a, xl, b, wlf, -1);
      end else begin
        rMode = $urandom_range(0, 1);
        doRead(a, xl, b);
        rMode = 0;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstAwready", awready, 1);
    checkOutput("rstArready", arready, 1);
    checkOutput("rstWready", wready, 0);
    checkOutput("rstBvalid", bvalid, 0);
    checkOutput("rstBresp", bresp, 0);
    checkOutput("rstRvalid", rvalid, 0);
    checkOutput("rstRlast", rlast, 0);
    checkOutput("rstRdata", rdata, 0);
    checkOutput("rstErr", error_count, 0);
    reset = 1'b0;

    wdQ = {32'h11, 32'h22, 32'h33, 32'h44};
    doWrite(4'h0, 4, INCR, 3, -1);
    doRead(4'h0, 4, INCR);

    wdQ = {32'hA, 32'hB, 32'hC};
    doWrite(4'hE, 3, INCR, 2, -1);
    doRead(4'hE, 3, INCR);

    wdQ = {32'h1, 32'h2, 32'h3};
    doWrite(4'h5, 3, FIXED, 2, -1);
    doRead(4'h5, 2, FIXED);

    doWrite(4'h8, 2, INCR, 0, -1);
    checkOutput("errAfterWlastMismatch", error_count, 1);
    doWrite(4'h9, 0, INCR, 0, -1);
    checkOutput("errAfterLenZero", error_count, 2);

    rPat = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    rMode = 2;
    doRead(4'h0, 3, INCR);
    rMode = 0;

    doWrite(4'h0, 4, INCR, 3, 2);
    doWrite(4'h0, 4, INCR, 3, -1);
    doRead(4'h0, 4, INCR);

    doWrite(4'h0, 16, INCR, 15, -1);
    fork
      doWrite(4'h8, 2, INCR, 1, -1);
      doRead(4'h0, 4, INCR);
    join

    applyStimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4_burst_memory_peripheral.md
Name: axi4_burst_memory_peripheral

Overview:
- Burst-capable AXI4 responder backed by a 2**ADDRESS_WIDTH x DATA_WIDTH register-array memory.
- It is the peripheral end for the axi4 controllers in lib/axi4.sv.
- It takes one address handshake per burst, then awlen/arlen data beats, and drives rlast itself.
- A single B response closes each write burst.
- It replaces per-beat address handshaking for the multi-beat SPI and AXI4 bridges.

Parameters:
ADDRESS_WIDTH, 4, memory word-address width; depth = 2**ADDRESS_WIDTH
DATA_WIDTH, 32, data word width
LEN_WIDTH, 5, width of awlen/arlen (number of beats, not beats-1)

Ports:
clock  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
awaddr  input  ADDRESS_WIDTH  first-beat write address
awlen  input  LEN_WIDTH  write beats in burst
awburst  input  3  axi::burst_t (FIXED=001, INCR=010, WRAP=100)
awvalid  input  1  AW valid
awready  output  1  AW ready
wdata  input  DATA_WIDTH  write data
wlast  input  1  controller's last-beat marker
wvalid  input  1  W valid
wready  output  1  W ready
bresp  output  1  1=OK, 0=error (codebase convention)
bvalid  output  1  B valid
bready  input  1  B ready
araddr  input  ADDRESS_WIDTH  first-beat read address
arlen  input  LEN_WIDTH  read beats in burst
arburst  input  3  axi::burst_t
arvalid  input  1  AR valid
arready  output  1  AR ready
rdata  output  DATA_WIDTH  read data
rlast  output  1  last read beat
rvalid  output  1  R valid
rready  input  1  R ready
error_count  output  32  saturating count of protocol errors

Behaviour:
- Reset (synchronous, active-high): awready=1, arready=1, wready=0, bvalid=0, bresp=0, rvalid=0, rlast=0, rdata=0, error_count=0, both FSMs to IDLE.
- Memory contents are not cleared by reset.
- A reset mid-burst abandons the burst. No B response is issued.
- Beat = valid & ready on the same posedge. Outputs are registered; no combinational input-to-output paths.
- Burst length: len = (xlen==0) ? 1 : xlen. xlen==0 also increments error_count.
- Address step:
  - INCR: addr+1, wrapping modulo 2**ADDRESS_WIDTH (0xF -> 0x0).
  - FIXED: addr unchanged.
  - WRAP or illegal encoding: treat as INCR and increment error_count.
- Write FSM W_IDLE:
  - awready=1, wready=0.
  - On AW beat: latch addr, len, burst; count=len; awready<=0, wready<=1; go to W_DATA.
- Write FSM W_DATA, on each W beat:
  - mem[addr]<=wdata; step addr; count<=count-1.
  - If wlast != (count==1): set sticky mismatch flag and increment error_count. The write still commits.
  - When count==1: wready<=0, bvalid<=1, bresp<=!flag_any (flag covers mismatch/len0/WRAP); go to W_RESP.
- Write FSM W_RESP:
  - Hold bvalid/bresp until bready.
  - On B beat: bvalid<=0, clear flags, awready<=1; go to W_IDLE.
- Write throughput: minimum burst = 1 AW cycle + len W cycles + 1 B cycle. The next AW is accepted the cycle after the B beat.
- Read FSM R_IDLE:
  - arready=1.
  - On AR beat: arready<=0; rdata<=mem[araddr]; rvalid<=1; rlast<=(len==1); latch next addr and count=len; go to R_DATA.
  - First rdata is valid the cycle after the AR handshake.
- Read FSM R_DATA, on R beat:
  - If rlast: rvalid<=0, rlast<=0, arready<=1; go to R_IDLE.
  - Otherwise: rdata<=mem[addr]; step addr; count-1; rlast<=(count==2); rvalid stays 1. This gives back-to-back beats with no bubble.
  - Without rready, rdata/rlast/rvalid hold stable.
- Read and write channels are fully independent and run concurrently.
- Same-cycle write and read of one address: the read returns the old data.
- error_count saturates at 32'hFFFFFFFF.

Test Plan:
- INCR write at 0x0, len=4, data 0x11,0x22,0x33,0x44, wlast on beat 4, bready=1 -> one B beat with bresp=1; then INCR read at 0x0, len=4, rready=1 -> rdata 0x11,0x22,0x33,0x44 on consecutive cycles, rlast on the 4th only, first beat 1 cycle after AR.
- INCR write at 0xE, len=3, data A,B,C -> mem[E]=A, mem[F]=B, mem[0]=C; read at 0xE len=3 returns A,B,C.
- FIXED write at 0x5, len=3, data 1,2,3 -> mem[5]=3, bresp=1; FIXED read at 0x5 len=2 -> 3,3 with rlast on the 2nd beat.
- Write len=2 with wlast asserted on beat 1 -> both beats written, bresp=0, error_count=1; awlen=0 burst -> 1 beat, bresp=0, error_count=2.
- Read len=3 with rready toggling 1,0,0,1,1 -> each rdata held while rready=0; exactly 3 beats; arready returns 1 the cycle after the last beat.
- Reset asserted mid write burst (after 2 of 4 beats) -> next cycle awready=1, wready=0, bvalid=0, error_count=0; a fresh burst then completes normally.
